// File: rtl/clk_div_bank_pkg.sv
// clk_div_bank_pkg: shared widths, defaults and helpers for the clk_div_bank divider slice.
package clk_div_bank_pkg;
    localparam int CDB_DIV_W = 16;
    localparam int CDB_DEF_DIV = 2;
    typedef struct packed {
        logic [CDB_DIV_W-1:0] div;
        logic [CDB_DIV_W-1:0] high;
    } chan_cfg_t;
    function automatic int clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/clk_div_chan.sv
// clk_div_chan: one divider channel with shadowed divisor applied at period boundaries.
// Optional CLK_DIV_BANK_DUTY_EN adds a programmable high-phase length.
module clk_div_chan #(
    parameter int DIV_W = 16,
    parameter int DEF_DIV = 2
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             wr,
    input  logic [DIV_W-1:0] wdiv,
`ifdef CLK_DIV_BANK_DUTY_EN
    input  logic [DIV_W-1:0] whigh,
`endif
    output logic             tick,
    output logic             clk_out,
    output logic             pend
);
    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);
    localparam logic [DIV_W-1:0] D0 = DIV_W'(DEF_DIV);
    logic [DIV_W-1:0] cnt, d, ds, cnt_nx, d_nx, h_eff;
    logic act, act_q, apply, on;
`ifdef CLK_DIV_BANK_DUTY_EN
    localparam logic [DIV_W-1:0] H0 = DIV_W'((DEF_DIV + 1) / 2);
    logic [DIV_W-1:0] h, hs, h_nx;
    assign h_nx = apply ? hs : h;
    assign h_eff = (h_nx > d_nx) ? d_nx : h_nx;
`else
    assign h_eff = DIV_W'(({1'b0, d_nx} + (DIV_W+1)'(1)) >> 1);
`endif
    // A fresh start (run rising or divisor leaving 0) restarts the period at cnt 0
    assign act = run && (d != '0);
    assign cnt_nx = (!act || !act_q || cnt >= d - ONE) ? '0 : cnt + ONE;
    assign apply = pend && (cnt_nx == '0);
    assign d_nx = apply ? ds : d;
    assign on = act && (d_nx != '0);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            d <= D0;
            ds <= D0;
            pend <= 1'b0;
            tick <= 1'b0;
            clk_out <= 1'b0;
            act_q <= 1'b0;
`ifdef CLK_DIV_BANK_DUTY_EN
            h <= H0;
            hs <= H0;
`endif
        end else begin
            cnt <= cnt_nx;
            d <= d_nx;
            pend <= wr || (pend && !apply);
            tick <= on && (cnt_nx == '0);
            clk_out <= on && (cnt_nx < h_eff);
            act_q <= on;
            if (wr) ds <= wdiv;
`ifdef CLK_DIV_BANK_DUTY_EN
            h <= h_nx;
            if (wr) hs <= whigh;
`endif
        end
    end
endmodule

// File: rtl/clk_div_bank.sv
// clk_div_bank: NUM_CH programmable clock-enable dividers with a valid/ready config port.
// Optional CLK_DIV_BANK_DUTY_EN adds cfg_high for programmable duty cycle.
module clk_div_bank
    import clk_div_bank_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DIV_W = CDB_DIV_W,
    parameter int DEF_DIV = CDB_DEF_DIV
)(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        run,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [clog2(NUM_CH):0]   cfg_ch,
    input  logic [DIV_W-1:0]         cfg_div,
`ifdef CLK_DIV_BANK_DUTY_EN
    input  logic [DIV_W-1:0]         cfg_high,
`endif
    output logic [NUM_CH-1:0]        tick,
    output logic [NUM_CH-1:0]        clk_out,
    output logic [NUM_CH-1:0]        pend
);
    localparam int CW = clog2(NUM_CH) + 1;
    localparam int PW = 1 << CW;
    logic [PW-1:0] pend_x;
    // Out-of-range channels read as never pending so their writes drain immediately
    assign pend_x = PW'(pend);
    assign cfg_ready = (int'(cfg_ch) >= NUM_CH) || !pend_x[cfg_ch];
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clk_div_chan #(.DIV_W(DIV_W), .DEF_DIV(DEF_DIV)) u_chan (
            .clk(clk),
            .rst_n(rst_n),
            .run(run[i]),
            .wr(cfg_valid && cfg_ready && (cfg_ch == CW'(i))),
            .wdiv(cfg_div),
`ifdef CLK_DIV_BANK_DUTY_EN
            .whigh(cfg_high),
`endif
            .tick(tick[i]),
            .clk_out(clk_out[i]),
            .pend(pend[i])
        );
    end
endmodule

// File: tb/tb_clk_div_bank.sv
// tb_clk_div_bank: scoreboard bench for clk_div_bank (4 channels, 16-bit divisors).
// Duty-cycle scenario is built only with CLK_DIV_BANK_DUTY_EN.
module tb_clk_div_bank;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [3:0] run = '0;
    logic cfg_valid = 1'b0;
    logic cfg_ready;
    logic [2:0] cfg_ch = '0;
    logic [15:0] cfg_div = '0;
    logic [15:0] cfg_high = '0;
    logic [3:0] tick, clk_out, pend;
    typedef struct {
        logic [3:0] t;
        logic [3:0] c;
        logic [3:0] p;
    } exp_t;
    exp_t sq[$];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    clk_div_bank #(.NUM_CH(4), .DIV_W(16), .DEF_DIV(2)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .run(run),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch),
        .cfg_div(cfg_div),
`ifdef CLK_DIV_BANK_DUTY_EN
        .cfg_high(cfg_high),
`endif
        .tick(tick),
        .clk_out(clk_out),
        .pend(pend)
    );

    // Expected {tick, clk_out} for cycle k of a running channel with divisor d, high length h
    function automatic logic [1:0] pat(input int d, input int h, input int k);
        int m = k % d;
        return {m == 0, m < h};
    endfunction

    task automatic push(input logic [3:0] t, input logic [3:0] c, input logic [3:0] p);
        sq.push_back('{t, c, p});
    endtask

    // Pop one expected cycle and compare it with the DUT just after the rising edge
    task automatic step(input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        if (sq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: scoreboard empty at %0t", nm, $time);
        end else begin
            e = sq.pop_front();
            checks += 3;
            if (tick !== e.t) begin
                failures++;
                $display("FAIL %s tick @%0t: got %b exp %b", nm, $time, tick, e.t);
            end
            if (clk_out !== e.c) begin
                failures++;
                $display("FAIL %s clk_out @%0t: got %b exp %b", nm, $time, clk_out, e.c);
            end
            if (pend !== e.p) begin
                failures++;
                $display("FAIL %s pend @%0t: got %b exp %b", nm, $time, pend, e.p);
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        run = '0;
        cfg_valid = 1'b0;
        cfg_ch = '0;
        cfg_div = '0;
        cfg_high = '0;
        repeat (2) @(negedge clk);
    endtask

    // Write a channel while every channel is idle: accepted, then applied on the next edge
    task automatic idle_write(input int ch, input int div, input int high);
        cfg_valid = 1'b1;
        cfg_ch = 3'(ch);
        cfg_div = 16'(div);
        cfg_high = 16'(high);
        checks++;
        if (cfg_ready !== 1'b1) begin
            failures++;
            $display("FAIL idle_write ready ch%0d: got %b exp 1", ch, cfg_ready);
        end
        push('0, '0, ch < 4 ? 4'(1 << ch) : 4'b0);
        step("idle_write accept");
        cfg_valid = 1'b0;
        push('0, '0, '0);
        step("idle_write apply");
    endtask

    task automatic test_reset();
        do_reset();
        checks += 4;
        if (tick !== 4'b0) begin failures++; $display("FAIL reset tick: got %b exp 0000", tick); end
        if (clk_out !== 4'b0) begin failures++; $display("FAIL reset clk_out: got %b exp 0000", clk_out); end
        if (pend !== 4'b0) begin failures++; $display("FAIL reset pend: got %b exp 0000", pend); end
        if (cfg_ready !== 1'b1) begin failures++; $display("FAIL reset cfg_ready: got %b exp 1", cfg_ready); end
        rst_n = 1'b1;
    endtask

    task automatic test_default();
        run = 4'hF;
        for (int k = 0; k < 6; k++) begin
            push((k % 2 == 0) ? 4'hF : 4'h0, (k % 2 == 0) ? 4'hF : 4'h0, '0);
            step("default_div2");
        end
    endtask

    task automatic test_divisors();
        logic [1:0] a, b;
        do_reset();
        rst_n = 1'b1;
        idle_write(0, 5, 0);
        idle_write(1, 4, 0);
        run = 4'b0011;
        for (int k = 0; k < 20; k++) begin
            a = pat(5, 3, k);
            b = pat(4, 2, k);
            push({2'b0, b[1], a[1]}, {2'b0, b[0], a[0]}, '0);
        end
        repeat (20) step("divisors_5_4");
    endtask

    // Mid-period rewrite of ch0 (5 -> 3), then a stalled second write (3 -> 6)
    task automatic test_reprogram();
        logic [1:0] a, b;
        logic [3:0] p;
        for (int k = 20; k <= 40; k++) begin
            if (k == 23) begin cfg_valid = 1'b1; cfg_ch = 3'd0; cfg_div = 16'd3; end
            if (k == 24) cfg_div = 16'd6;
            if (k == 27) cfg_valid = 1'b0;
            if (k >= 23 && k <= 26) begin
                checks++;
                if (cfg_ready !== (k == 23 || k == 26)) begin
                    failures++;
                    $display("FAIL reprogram cfg_ready k=%0d: got %b exp %b", k, cfg_ready, (k == 23 || k == 26));
                end
            end
            a = k < 25 ? pat(5, 3, k) : k < 28 ? pat(3, 2, k - 25) : pat(6, 3, k - 28);
            b = pat(4, 2, k);
            p = ((k >= 23 && k <= 24) || (k >= 26 && k <= 27)) ? 4'b0001 : 4'b0000;
            push({2'b0, b[1], a[1]}, {2'b0, b[0], a[0]}, p);
            step("reprogram");
        end
    endtask

    task automatic test_stop_and_edges();
        logic [1:0] a;
        do_reset();
        rst_n = 1'b1;
        idle_write(2, 7, 0);
        run = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            a = pat(7, 4, k);
            push({1'b0, a[1], 2'b0}, {1'b0, a[0], 2'b0}, '0);
            step("run_d7");
        end
        cfg_valid = 1'b1; cfg_ch = 3'd2; cfg_div = 16'd4;
        a = pat(7, 4, 3);
        push({1'b0, a[1], 2'b0}, {1'b0, a[0], 2'b0}, 4'b0100);
        step("write_while_running");
        cfg_valid = 1'b0;
        run = 4'b0000;
        push('0, '0, '0);
        step("stop_applies_pending");
        push('0, '0, '0);
        step("stopped");
        run = 4'b0100;
        for (int k = 0; k < 12; k++) begin
            if (k == 8) begin cfg_valid = 1'b1; cfg_ch = 3'd2; cfg_div = 16'd0; end
            if (k == 9) cfg_valid = 1'b0;
            a = pat(4, 2, k);
            push({1'b0, a[1], 2'b0}, {1'b0, a[0], 2'b0}, (k >= 8) ? 4'b0100 : 4'b0000);
            step("restart_d4");
        end
        repeat (3) begin
            push('0, '0, '0);
            step("d0_held_off");
        end
        idle_write(4, 9, 0);
        idle_write(2, 3, 0);
        for (int k = 0; k < 3; k++) begin
            a = pat(3, 2, k);
            push({1'b0, a[1], 2'b0}, {1'b0, a[0], 2'b0}, '0);
            step("run_d3");
        end
        cfg_valid = 1'b1; cfg_ch = 3'd2; cfg_div = 16'd9;
        push(4'b0100, 4'b0100, 4'b0100);
        step("write_before_reset");
        cfg_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks += 4;
        if (tick !== 4'b0) begin failures++; $display("FAIL async_reset tick: got %b exp 0000", tick); end
        if (clk_out !== 4'b0) begin failures++; $display("FAIL async_reset clk_out: got %b exp 0000", clk_out); end
        if (pend !== 4'b0) begin failures++; $display("FAIL async_reset pend: got %b exp 0000", pend); end
        if (cfg_ready !== 1'b1) begin failures++; $display("FAIL async_reset cfg_ready: got %b exp 1", cfg_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            a = pat(2, 1, k);
            push({1'b0, a[1], 2'b0}, {1'b0, a[0], 2'b0}, '0);
            step("after_reset_d2");
        end
    endtask

`ifdef CLK_DIV_BANK_DUTY_EN
    task automatic test_duty();
        logic [1:0] a;
        int hs[3] = '{2, 10, 0};
        do_reset();
        rst_n = 1'b1;
        for (int j = 0; j < 3; j++) begin
            run = 4'b0000;
            push('0, '0, '0);
            step("duty_stop");
            idle_write(0, 8, hs[j]);
            run = 4'b0001;
            for (int k = 0; k < 16; k++) begin
                a = pat(8, hs[j], k);
                push({3'b0, a[1]}, {3'b0, a[0]}, '0);
                step("duty_d8");
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_default();
        test_divisors();
        test_reprogram();
        test_stop_and_edges();
`ifdef CLK_DIV_BANK_DUTY_EN
        test_duty();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
